md_unit: RTL

Multiply/divide unit in the EX stage, beside `alu`. It takes the same forwarded `A` and `B` operands and runs MIPS `MULT`, `MULTU`, `DIV`, `DIVU`, `MTHI` and `MTLO` against the architectural `HI`/`LO` registers. Multiply and divide take several cycles and are signalled by `Busy`; the hazard unit uses `Busy` to stall any HI/LO-touching instruction in ID. `MFHI`/`MFLO` read the `HI`/`LO` outputs directly.

---
 rtl/md_pkg.sv | 37 +++
 rtl/md_arith.sv | 93 +++++++++
 rtl/md_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - MD_* operation codes driven on MdOp by the decoder
//   - default Busy lengths for multiply and divide
//   - sequencer state encoding
//   - helper that sizes the Busy counter from the two cycle counts
package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'b0000;
    localparam logic [3:0] MD_MULT  = 4'b0001;
    localparam logic [3:0] MD_MULTU = 4'b0010;
    localparam logic [3:0] MD_DIV   = 4'b0011;
    localparam logic [3:0] MD_DIVU  = 4'b0100;
    localparam logic [3:0] MD_MTHI  = 4'b0101;
    localparam logic [3:0] MD_MTLO  = 4'b0110;

    localparam int unsigned MD_MULT_CYCLES_DEF = 32'd5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 32'd10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // The counter holds N-1 down to 0, so it needs enough bits for
    // max(MULT_CYCLES, DIV_CYCLES) - 1, and never fewer than one bit.
    function automatic int md_cnt_width(input int unsigned mult_n,
                                        input int unsigned div_n);
        int unsigned m;
        m = (mult_n > div_n) ? mult_n : div_n;
        if (m <= 32'd2) begin
            return 1;
        end else begin
            return $clog2(m);
        end
    endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational datapath of the multiply/divide unit.
// Ports:
//   a_i, b_i      32-bit operands (rs, rt)
//   md_op_i       operation code (md_pkg MD_*)
//   res_hi_o      value destined for HI (product high / remainder)
//   res_lo_o      value destined for LO (product low / quotient)
//   div_zero_o    divide op with b_i == 0; the result must not be committed
module md_arith
    import md_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  md_op_i,
    output logic [31:0] res_hi_o,
    output logic [31:0] res_lo_o,
    output logic        div_zero_o
);

    logic signed [63:0] a_sext_s;
    logic signed [63:0] b_sext_s;
    logic signed [63:0] prod_signed_s;
    logic        [63:0] prod_unsigned_s;

    logic               div_signed_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic        [31:0] a_mag_s;
    logic        [31:0] b_mag_s;
    logic        [31:0] divisor_s;
    logic        [31:0] q_mag_s;
    logic        [31:0] r_mag_s;
    logic        [31:0] quot_s;
    logic        [31:0] rem_s;

    // Both products are formed full-width; the opcode picks one below.
    always_comb begin
        a_sext_s        = {{32{a_i[31]}}, a_i};
        b_sext_s        = {{32{b_i[31]}}, b_i};
        prod_signed_s   = a_sext_s * b_sext_s;
        prod_unsigned_s = {32'd0, a_i} * {32'd0, b_i};
    end

    // Signed divide is done as an unsigned divide of magnitudes with the
    // signs reapplied: the quotient truncates toward zero and the
    // remainder follows the dividend. This also makes 0x80000000 / -1
    // come out as 0x80000000 rem 0 without any overflow special case.
    always_comb begin
        div_signed_s = (md_op_i == MD_DIV);
        a_neg_s      = div_signed_s & a_i[31];
        b_neg_s      = div_signed_s & b_i[31];
        a_mag_s      = a_neg_s ? (~a_i + 32'd1) : a_i;
        b_mag_s      = b_neg_s ? (~b_i + 32'd1) : b_i;
        // A zero divisor is replaced so the divider never sees it; the
        // result is discarded through div_zero_o anyway.
        if (b_i == 32'd0) begin
            divisor_s = 32'd1;
        end else begin
            divisor_s = b_mag_s;
        end
        q_mag_s = a_mag_s / divisor_s;
        r_mag_s = a_mag_s % divisor_s;
        quot_s  = (a_neg_s ^ b_neg_s) ? (~q_mag_s + 32'd1) : q_mag_s;
        rem_s   = a_neg_s ? (~r_mag_s + 32'd1) : r_mag_s;
    end

    // Result selection by opcode.
    always_comb begin
        res_hi_o   = 32'd0;
        res_lo_o   = 32'd0;
        div_zero_o = 1'b0;
        case (md_op_i)
            MD_MULT: begin
                res_hi_o = prod_signed_s[63:32];
                res_lo_o = prod_signed_s[31:0];
            end
            MD_MULTU: begin
                res_hi_o = prod_unsigned_s[63:32];
                res_lo_o = prod_unsigned_s[31:0];
            end
            MD_DIV, MD_DIVU: begin
                res_hi_o   = rem_s;
                res_lo_o   = quot_s;
                div_zero_o = (b_i == 32'd0);
            end
            default: begin
                res_hi_o   = 32'd0;
                res_lo_o   = 32'd0;
                div_zero_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning the architectural HI/LO.
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   A, B         forwarded rs/rt operands, sampled only at the accepting edge
//   MdOp, Start  command; accepted when Start=1 and Busy=0
//   Busy         registered, high for the N cycles of a multiply/divide
//   HI, LO       architectural registers (register outputs)
// The result of a multiply/divide is computed at acceptance and parked in
// pending registers; HI/LO are updated only at the edge ending the last
// Busy cycle, so the latency seen by software is set purely by the counter.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MdOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_W = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

    md_state_e          state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;
    logic               pend_nowr_q, pend_nowr_d;
    logic [31:0]        hi_q,      hi_d;
    logic [31:0]        lo_q,      lo_d;
    logic               busy_q,    busy_d;

    logic [31:0]        res_hi_s;
    logic [31:0]        res_lo_s;
    logic               div_zero_s;

    md_arith u_arith (
        .a_i        (A),
        .b_i        (B),
        .md_op_i    (MdOp),
        .res_hi_o   (res_hi_s),
        .res_lo_o   (res_lo_s),
        .div_zero_o (div_zero_s)
    );

    // Next-state logic: command acceptance in IDLE, countdown and commit in RUN.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        pend_nowr_d = pend_nowr_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            MD_IDLE: begin
                if (Start) begin
                    case (MdOp)
                        MD_MULT, MD_MULTU: begin
                            pend_hi_d   = res_hi_s;
                            pend_lo_d   = res_lo_s;
                            pend_nowr_d = 1'b0;
                            cnt_d       = CNT_W'(MULT_CYCLES - 32'd1);
                            state_d     = MD_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            pend_hi_d   = res_hi_s;
                            pend_lo_d   = res_lo_s;
                            pend_nowr_d = div_zero_s;
                            cnt_d       = CNT_W'(DIV_CYCLES - 32'd1);
                            state_d     = MD_RUN;
                        end
                        MD_MTHI: begin
                            hi_d = A;
                        end
                        MD_MTLO: begin
                            lo_d = A;
                        end
                        default: begin
                            state_d = MD_IDLE;
                        end
                    endcase
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_RUN: begin
                // Start is deliberately not looked at here: no queuing.
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = MD_IDLE;
                    if (!pend_nowr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1'b1);
                end
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
        busy_d = (state_d == MD_RUN);
    end

    // State, counter, pending result and architectural HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MD_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            pend_hi_q   <= 32'd0;
            pend_lo_q   <= 32'd0;
            pend_nowr_q <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            pend_nowr_q <= pend_nowr_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            busy_q      <= busy_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
